// File: rtl/vec_pkg.sv
// Shared constants, FSM state and FIFO entry type for the vector operand fetch block.
package vec_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int ADDR_WIDTH   = 5;
    localparam int OFF_BITS     = 8;
    localparam int PACK_PER_REG = 256;
    localparam int FIFO_DEPTH   = 2;

    // One extra bit so a count of PACK_PER_REG is representable without wrapping.
    typedef logic [OFF_BITS:0] cnt_t;

    localparam cnt_t PKT_MAX = cnt_t'(PACK_PER_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } opf_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data_1;
        logic [DATA_WIDTH-1:0] data_2;
        logic [OFF_BITS-1:0]   off;
        logic                  last;
    } opf_entry_t;

endpackage

// File: rtl/vec_operand_fetch_if.sv
// Operand pair channel towards the vector ALU.
// Handshake: a pair transfers on a rising edge where op_valid & op_ready; once op_valid is
// raised the producer holds op_* stable until that transfer, and op_valid never depends on op_ready.
interface vec_operand_fetch_if;
    import vec_pkg::*;

    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_data_1;
    logic [DATA_WIDTH-1:0] op_data_2;
    logic [OFF_BITS-1:0]   op_off;
    logic                  op_last;

    modport master (
        output op_valid, op_data_1, op_data_2, op_off, op_last,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_data_1, op_data_2, op_off, op_last,
        output op_ready
    );

endinterface

// File: rtl/vec_opf_fifo.sv
// Two-entry first-word-fall-through buffer for returned operand pairs.
module vec_opf_fifo
    import vec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  opf_entry_t push_data_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output opf_entry_t head_o
);

    opf_entry_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/vec_operand_fetch.sv
// Walks packet offsets of one operand request, drives both regfile read ports and buffers
// the 1-cycle-late read data into aligned operand pairs. Optional macro: VEC_OPF_SCALAR_EN.
module vec_operand_fetch
    import vec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_vs1,
    input  logic [ADDR_WIDTH-1:0] req_vs2,
    input  logic [OFF_BITS:0]     req_npkt,
    input  logic                  req_scalar,
    input  logic [DATA_WIDTH-1:0] req_scalar_data,
    output logic                  rd_en_1,
    output logic                  rd_en_2,
    output logic [ADDR_WIDTH-1:0] rd_addr_1,
    output logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic [OFF_BITS-1:0]   rd_off_1,
    output logic [OFF_BITS-1:0]   rd_off_2,
    input  logic [DATA_WIDTH-1:0] rd_data_1,
    input  logic [DATA_WIDTH-1:0] rd_data_2,
    vec_operand_fetch_if.master   op,
    output logic                  busy,
    output opf_state_t            dbg_state_o
);

    opf_state_t            state_q;
    logic [ADDR_WIDTH-1:0] vs1_q;
    logic [ADDR_WIDTH-1:0] vs2_q;
    cnt_t                  npkt_q;
    cnt_t                  off_q;
    logic                  inflight_q;
    logic [OFF_BITS-1:0]   infl_off_q;
    logic                  infl_last_q;

    logic       pop;
    logic       issue;
    logic       issue_last;
    logic       accept;
    logic       drain_done;
    logic [2:0] occ;
    logic [1:0] fifo_count;
    cnt_t       npkt_sat;
    opf_entry_t push_entry;
    opf_entry_t head;
    logic [DATA_WIDTH-1:0] push_data_2;

    assign accept     = req_valid & req_ready;
    assign npkt_sat   = (req_npkt > PKT_MAX) ? PKT_MAX : req_npkt;
    assign pop        = op.op_valid & op.op_ready;

    // Slots already committed (held + in flight) after this cycle's pop must leave room.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == ISSUE) && (occ < 3'(FIFO_DEPTH));
    assign issue_last = (off_q == (npkt_q - cnt_t'(1)));
    assign drain_done = !inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vs1_q       <= '0;
            vs2_q       <= '0;
            npkt_q      <= '0;
            off_q       <= '0;
            inflight_q  <= 1'b0;
            infl_off_q  <= '0;
            infl_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                infl_off_q  <= off_q[OFF_BITS-1:0];
                infl_last_q <= issue_last;
                off_q       <= off_q + cnt_t'(1);
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        vs1_q  <= req_vs1;
                        vs2_q  <= req_vs2;
                        npkt_q <= npkt_sat;
                        off_q  <= '0;
                        if (npkt_sat != '0) state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && issue_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef VEC_OPF_SCALAR_EN
    logic                  scalar_q;
    logic [DATA_WIDTH-1:0] scalar_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scalar_q      <= 1'b0;
            scalar_data_q <= '0;
        end else if (accept) begin
            scalar_q      <= req_scalar;
            scalar_data_q <= req_scalar_data;
        end
    end

    assign rd_en_2     = issue & ~scalar_q;
    assign push_data_2 = scalar_q ? scalar_data_q : rd_data_2;
`else
    logic unused_scalar;
    assign unused_scalar = ^{req_scalar, req_scalar_data};
    assign rd_en_2       = issue;
    assign push_data_2   = rd_data_2;
`endif

    assign rd_en_1   = issue;
    assign rd_addr_1 = vs1_q;
    assign rd_addr_2 = vs2_q;
    assign rd_off_1  = off_q[OFF_BITS-1:0];
    assign rd_off_2  = off_q[OFF_BITS-1:0];

    assign push_entry.data_1 = rd_data_1;
    assign push_entry.data_2 = push_data_2;
    assign push_entry.off    = infl_off_q;
    assign push_entry.last   = infl_last_q;

    vec_opf_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (head)
    );

    assign op.op_valid  = (fifo_count != 2'd0);
    assign op.op_data_1 = head.data_1;
    assign op.op_data_2 = head.data_2;
    assign op.op_off    = head.off;
    assign op.op_last   = head.last;

    assign req_ready   = (state_q == IDLE) & ~rst;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vec_operand_fetch.sv
// Directed bench for vec_operand_fetch with a behavioural 1-cycle-latency regfile.
module tb_vec_operand_fetch;
    import vec_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_vs1;
    logic [ADDR_WIDTH-1:0] req_vs2;
    logic [OFF_BITS:0]     req_npkt;
    logic                  req_scalar;
    logic [DATA_WIDTH-1:0] req_scalar_data;
    logic                  rd_en_1;
    logic                  rd_en_2;
    logic [ADDR_WIDTH-1:0] rd_addr_1;
    logic [ADDR_WIDTH-1:0] rd_addr_2;
    logic [OFF_BITS-1:0]   rd_off_1;
    logic [OFF_BITS-1:0]   rd_off_2;
    logic [DATA_WIDTH-1:0] rd_data_1;
    logic [DATA_WIDTH-1:0] rd_data_2;
    logic                  busy;
    opf_state_t            dbg_state;
    logic                  op_ready;
    logic                  op_valid;
    logic [DATA_WIDTH-1:0] op_data_1;
    logic [DATA_WIDTH-1:0] op_data_2;
    logic [OFF_BITS-1:0]   op_off;
    logic                  op_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_operand_fetch_if op_if ();

    assign op_if.op_ready = op_ready;
    assign op_valid  = op_if.op_valid;
    assign op_data_1 = op_if.op_data_1;
    assign op_data_2 = op_if.op_data_2;
    assign op_off    = op_if.op_off;
    assign op_last   = op_if.op_last;

    vec_operand_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_vs1         (req_vs1),
        .req_vs2         (req_vs2),
        .req_npkt        (req_npkt),
        .req_scalar      (req_scalar),
        .req_scalar_data (req_scalar_data),
        .rd_en_1         (rd_en_1),
        .rd_en_2         (rd_en_2),
        .rd_addr_1       (rd_addr_1),
        .rd_addr_2       (rd_addr_2),
        .rd_off_1        (rd_off_1),
        .rd_off_2        (rd_off_2),
        .rd_data_1       (rd_data_1),
        .rd_data_2       (rd_data_2),
        .op              (op_if.master),
        .busy            (busy),
        .dbg_state_o     (dbg_state)
    );

    // Regfile contents are a pure function of register and packet offset.
    function automatic logic [63:0] rf_val(input logic [4:0] a, input logic [7:0] o);
        return {16'hC0DE, 11'd0, a, 24'd0, o};
    endfunction

    always @(posedge clk) begin
        if (rd_en_1) rd_data_1 <= rf_val(rd_addr_1, rd_off_1);
        if (rd_en_2) rd_data_2 <= rf_val(rd_addr_2, rd_off_2);
    end

    // ---------------- monitor: popped pairs, issues, occupancy, stall stability ----------------
    opf_entry_t obs_q[$];
    opf_entry_t cur_e;
    opf_entry_t prev_e;
    logic       prev_stall = 1'b0;
    int         outst      = 0;
    int         outst_viol = 0;
    int         stall_viol = 0;
    int         iss1_cnt   = 0;
    int         iss2_cnt   = 0;
    int         valid_cyc  = 0;

    always @(negedge clk) begin
        #2;
        cur_e.data_1 = op_data_1;
        cur_e.data_2 = op_data_2;
        cur_e.off    = op_off;
        cur_e.last   = op_last;
        if (rst) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!op_valid || cur_e !== prev_e)) stall_viol++;
            outst = outst + int'(rd_en_1) - int'(op_valid && op_ready);
            if (outst > 2) outst_viol++;
            if (rd_en_1) iss1_cnt++;
            if (rd_en_2) iss2_cnt++;
            if (op_valid) valid_cyc++;
            if (op_valid && op_ready) obs_q.push_back(cur_e);
            prev_stall = op_valid && !op_ready;
            prev_e     = cur_e;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send_req(input logic [4:0] v1, input logic [4:0] v2, input logic [8:0] n,
                            input logic sc, input logic [63:0] sd);
        req_vs1         = v1;
        req_vs2         = v2;
        req_npkt        = n;
        req_scalar      = sc;
        req_scalar_data = sd;
        req_valid       = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Runs cycles until n more pairs have been popped or max_cyc elapses; bp selects the
    // 1,0,0,1 op_ready pattern. first/last are cycle indices with op_valid high.
    task automatic run_until(input int n, input int max_cyc, input bit bp,
                             output int first, output int last);
        int base;
        base  = obs_q.size();
        first = -1;
        last  = -1;
        for (int i = 0; i < max_cyc; i++) begin
            op_ready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            #1;
            if (op_valid) begin
                if (first < 0) first = i;
                last = i;
            end
            #2;
            if (obs_q.size() - base >= n) break;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_vs1 = '0; req_vs2 = '0; req_npkt = '0;
        req_scalar = 1'b0; req_scalar_data = '0; op_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if ({rd_en_1, rd_en_2} !== 2'b00) $display("FAIL reset_rd_en: got %b want 00", {rd_en_1, rd_en_2}); else pass_cnt++;
        total_cnt++; if (op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b want 0", op_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else pass_cnt++;
        total_cnt++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL post_reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_single();
        op_ready = 1'b1;
        send_req(5'd3, 5'd7, 9'd1, 1'b0, 64'd0);
        #1;
        total_cnt++; if ({rd_en_1, rd_en_2} !== 2'b11) $display("FAIL single_rd_en: got %b want 11", {rd_en_1, rd_en_2}); else pass_cnt++;
        total_cnt++; if ({rd_addr_1, rd_addr_2} !== {5'd3, 5'd7}) $display("FAIL single_rd_addr: got %0d/%0d want 3/7", rd_addr_1, rd_addr_2); else pass_cnt++;
        total_cnt++; if ({rd_off_1, rd_off_2} !== 16'd0) $display("FAIL single_rd_off: got %0d/%0d want 0/0", rd_off_1, rd_off_2); else pass_cnt++;
        total_cnt++; if ({busy, op_valid} !== 2'b10) $display("FAIL single_busy_valid_c1: got %b want 10", {busy, op_valid}); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if ({rd_en_1, op_valid} !== 2'b00) $display("FAIL single_c2: got %b want 00", {rd_en_1, op_valid}); else pass_cnt++;
        // Third cycle after the accept cycle: the pair is visible.
        @(negedge clk); #1;
        total_cnt++; if (op_valid !== 1'b1) $display("FAIL single_latency: got op_valid %b want 1", op_valid); else pass_cnt++;
        total_cnt++; if ({op_off, op_last} !== {8'd0, 1'b1}) $display("FAIL single_off_last: got %0d/%b want 0/1", op_off, op_last); else pass_cnt++;
        total_cnt++; if ({op_data_1, op_data_2} !== {rf_val(5'd3, 8'd0), rf_val(5'd7, 8'd0)}) $display("FAIL single_data: got %h/%h want %h/%h", op_data_1, op_data_2, rf_val(5'd3, 8'd0), rf_val(5'd7, 8'd0)); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if ({op_valid, busy, req_ready} !== 3'b001) $display("FAIL single_done: got %b want 001", {op_valid, busy, req_ready}); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        int base, iss0, first, last;
        opf_entry_t exp_e;
        base = obs_q.size();
        iss0 = iss1_cnt;
        send_req(5'd4, 5'd9, 9'd256, 1'b0, 64'd0);
        run_until(256, 400, 1'b0, first, last);
        total_cnt++; if (obs_q.size() - base !== 256) $display("FAIL stream_count: got %0d want 256", obs_q.size() - base); else pass_cnt++;
        total_cnt++; if (first !== 2) $display("FAIL stream_latency: got first valid at %0d want 2", first); else pass_cnt++;
        total_cnt++; if (last - first + 1 !== 256) $display("FAIL stream_gaps: got span %0d want 256", last - first + 1); else pass_cnt++;
        total_cnt++; if (iss1_cnt - iss0 !== 256) $display("FAIL stream_issues: got %0d want 256", iss1_cnt - iss0); else pass_cnt++;
        for (int k = 0; k < 256; k++) begin
            exp_e.data_1 = rf_val(5'd4, 8'(k));
            exp_e.data_2 = rf_val(5'd9, 8'(k));
            exp_e.off    = 8'(k);
            exp_e.last   = (k == 255);
            total_cnt++;
            if (base + k >= obs_q.size()) $display("FAIL stream_pair_%0d: got missing want off %0d", k, k);
            else if (obs_q[base + k] !== exp_e) $display("FAIL stream_pair_%0d: got %h want %h", k, obs_q[base + k], exp_e);
            else pass_cnt++;
        end
        @(negedge clk); #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL stream_idle: got busy %b want 0", busy); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int base, iss0, ov0, sv0, first, last;
        opf_entry_t exp_e;
        base = obs_q.size();
        iss0 = iss1_cnt;
        ov0  = outst_viol;
        sv0  = stall_viol;
        send_req(5'd2, 5'd5, 9'd8, 1'b0, 64'd0);
        run_until(8, 100, 1'b1, first, last);
        total_cnt++; if (obs_q.size() - base !== 8) $display("FAIL bp_count: got %0d want 8", obs_q.size() - base); else pass_cnt++;
        total_cnt++; if (iss1_cnt - iss0 !== 8) $display("FAIL bp_issues: got %0d want 8", iss1_cnt - iss0); else pass_cnt++;
        total_cnt++; if (outst_viol - ov0 !== 0) $display("FAIL bp_occupancy: got %0d overfull cycles want 0", outst_viol - ov0); else pass_cnt++;
        total_cnt++; if (stall_viol - sv0 !== 0) $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol - sv0); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            exp_e.data_1 = rf_val(5'd2, 8'(k));
            exp_e.data_2 = rf_val(5'd5, 8'(k));
            exp_e.off    = 8'(k);
            exp_e.last   = (k == 7);
            total_cnt++;
            if (base + k >= obs_q.size()) $display("FAIL bp_pair_%0d: got missing want off %0d", k, k);
            else if (obs_q[base + k] !== exp_e) $display("FAIL bp_pair_%0d: got %h want %h", k, obs_q[base + k], exp_e);
            else pass_cnt++;
        end
        op_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_edge_counts();
        int base, iss0, v0, first, last;
        logic busy_seen;
        base = obs_q.size();
        iss0 = iss1_cnt;
        v0   = valid_cyc;
        busy_seen = 1'b0;
        op_ready = 1'b1;
        send_req(5'd1, 5'd1, 9'd0, 1'b0, 64'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (busy) busy_seen = 1'b1;
            @(negedge clk);
        end
        #3;
        total_cnt++; if (busy_seen !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy_seen); else pass_cnt++;
        total_cnt++; if (valid_cyc - v0 !== 0) $display("FAIL zero_valid: got %0d want 0", valid_cyc - v0); else pass_cnt++;
        total_cnt++; if (iss1_cnt - iss0 !== 0) $display("FAIL zero_issue: got %0d want 0", iss1_cnt - iss0); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL zero_req_ready: got %b want 1", req_ready); else pass_cnt++;
        @(negedge clk);
        base = obs_q.size();
        send_req(5'd12, 5'd13, 9'd300, 1'b0, 64'd0);
        run_until(300, 400, 1'b0, first, last);
        repeat (4) @(negedge clk);
        #3;
        total_cnt++; if (obs_q.size() - base !== 256) $display("FAIL sat_count: got %0d want 256", obs_q.size() - base); else pass_cnt++;
        total_cnt++;
        if (obs_q.size() - base < 256) $display("FAIL sat_last: got missing want off 255 last");
        else if ({obs_q[base + 255].off, obs_q[base + 255].last} !== {8'd255, 1'b1}) $display("FAIL sat_last: got %0d/%b want 255/1", obs_q[base + 255].off, obs_q[base + 255].last);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base, first, last;
        base = obs_q.size();
        send_req(5'd6, 5'd8, 9'd16, 1'b0, 64'd0);
        run_until(5, 50, 1'b0, first, last);
        rst = 1'b1;
        #1;
        total_cnt++; if ({op_valid, rd_en_1, rd_en_2, busy} !== 4'b0000) $display("FAIL midrst_outputs: got %b want 0000", {op_valid, rd_en_1, rd_en_2, busy}); else pass_cnt++;
        total_cnt++; if (obs_q.size() - base !== 5) $display("FAIL midrst_pairs: got %0d want 5", obs_q.size() - base); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = obs_q.size();
        send_req(5'd1, 5'd2, 9'd2, 1'b0, 64'd0);
        #1;
        total_cnt++; if ({rd_en_1, rd_addr_1, rd_off_1} !== {1'b1, 5'd1, 8'd0}) $display("FAIL midrst_restart: got %b/%0d/%0d want 1/1/0", rd_en_1, rd_addr_1, rd_off_1); else pass_cnt++;
        @(negedge clk);
        run_until(2, 20, 1'b0, first, last);
        total_cnt++;
        if (obs_q.size() - base < 2) $display("FAIL midrst_new_pairs: got %0d want 2", obs_q.size() - base);
        else if ({obs_q[base].off, obs_q[base].data_1, obs_q[base + 1].off, obs_q[base + 1].last} !== {8'd0, rf_val(5'd1, 8'd0), 8'd1, 1'b1})
            $display("FAIL midrst_new_pairs: got off %0d data %h off %0d last %b want 0 %h 1 1", obs_q[base].off, obs_q[base].data_1, obs_q[base + 1].off, obs_q[base + 1].last, rf_val(5'd1, 8'd0));
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scalar();
        int base, iss1_0, iss2_0, first, last;
        logic [63:0] want_2;
        base   = obs_q.size();
        iss1_0 = iss1_cnt;
        iss2_0 = iss2_cnt;
        send_req(5'd10, 5'd11, 9'd4, 1'b1, 64'hDEAD_BEEF_0000_0001);
        run_until(4, 30, 1'b0, first, last);
        total_cnt++; if (iss1_cnt - iss1_0 !== 4) $display("FAIL scalar_port1_issues: got %0d want 4", iss1_cnt - iss1_0); else pass_cnt++;
`ifdef VEC_OPF_SCALAR_EN
        total_cnt++; if (iss2_cnt - iss2_0 !== 0) $display("FAIL scalar_port2_issues: got %0d want 0", iss2_cnt - iss2_0); else pass_cnt++;
`else
        total_cnt++; if (iss2_cnt - iss2_0 !== 4) $display("FAIL scalar_port2_issues: got %0d want 4", iss2_cnt - iss2_0); else pass_cnt++;
`endif
        for (int k = 0; k < 4; k++) begin
`ifdef VEC_OPF_SCALAR_EN
            want_2 = 64'hDEAD_BEEF_0000_0001;
`else
            want_2 = rf_val(5'd11, 8'(k));
`endif
            total_cnt++;
            if (base + k >= obs_q.size()) $display("FAIL scalar_pair_%0d: got missing want off %0d", k, k);
            else if ({obs_q[base + k].off, obs_q[base + k].data_1, obs_q[base + k].data_2} !== {8'(k), rf_val(5'd10, 8'(k)), want_2})
                $display("FAIL scalar_pair_%0d: got %0d %h %h want %0d %h %h", k, obs_q[base + k].off, obs_q[base + k].data_1, obs_q[base + k].data_2, k, rf_val(5'd10, 8'(k)), want_2);
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_edge_counts();
        test_reset_mid();
        test_scalar();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
